// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - MSB-first parallel-in serial-out transmitter with gapless back-to-back framing
// Define PISO_PARITY_EN to append one even-parity bit after every word.
module piso_serializer #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] data_in,
    input  logic         load_valid,
    output logic         load_ready,
    output logic         serial_out,
    output logic         frame_active,
    output logic         last_bit
);

    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [N-1:0]     shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_fire;
`ifdef PISO_PARITY_EN
    logic             parity_q, parity_d;
`endif

    assign load_fire = load_valid & load_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
`ifdef PISO_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
`ifdef PISO_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // A load restarts a frame from any state that currently offers load_ready.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
`ifdef PISO_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (load_fire) begin
                    state_d  = ST_SHIFT;
                    shift_d  = data_in;
                    cnt_d    = '0;
`ifdef PISO_PARITY_EN
                    parity_d = ^data_in;
`endif
                end
            end
            ST_SHIFT: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
`ifdef PISO_PARITY_EN
                    state_d = ST_PARITY;
                    shift_d = '0;
`else
                    if (load_fire) begin
                        state_d = ST_SHIFT;
                        shift_d = data_in;
                    end else begin
                        state_d = ST_IDLE;
                        shift_d = '0;
                    end
`endif
                end else begin
                    shift_d = {shift_q[N-2:0], 1'b0};
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
`ifdef PISO_PARITY_EN
            ST_PARITY: begin
                cnt_d = '0;
                if (load_fire) begin
                    state_d  = ST_SHIFT;
                    shift_d  = data_in;
                    parity_d = ^data_in;
                end else begin
                    state_d  = ST_IDLE;
                    shift_d  = '0;
                    parity_d = 1'b0;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                shift_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // load_ready depends only on state, never on load_valid, so no combinational loop to the source.
    always_comb begin
        serial_out   = 1'b0;
        frame_active = 1'b0;
        last_bit     = 1'b0;
        case (state_q)
            ST_SHIFT: begin
                serial_out   = shift_q[N-1];
                frame_active = 1'b1;
`ifndef PISO_PARITY_EN
                last_bit     = (cnt_q == CNT_LAST);
`endif
            end
`ifdef PISO_PARITY_EN
            ST_PARITY: begin
                serial_out   = parity_q;
                frame_active = 1'b1;
                last_bit     = 1'b1;
            end
`endif
            default: begin
                serial_out   = 1'b0;
                frame_active = 1'b0;
                last_bit     = 1'b0;
            end
        endcase
        load_ready = (state_q == ST_IDLE) || last_bit;
    end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in serial-out transmitter: the sending end of the serial shift links fed into our SISO shift-register chains.
- Accepts an N-bit word over a valid/ready handshake and shifts it out MSB first, one bit per clock.
- An N-stage shift-left chain on the receive side ends up holding the word in its original bit order.
- Gapless back-to-back framing, so consecutive words stream without idle cycles.

Parameters:
N, 8, data word width in bits; legal range N >= 2.

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
data_in  input  N  parallel word to transmit
load_valid  input  1  data_in is valid and requests transmission
load_ready  output  1  block can accept a word this cycle
serial_out  output  1  serial data bit, MSB first
frame_active  output  1  high on every cycle serial_out carries a frame bit
last_bit  output  1  high on the cycle serial_out carries the final bit of a frame

Behaviour:
- Reset: while reset_n = 0, asynchronously force the following state:
  - state IDLE, shift register 0, bit counter 0
  - serial_out = 0, frame_active = 0, last_bit = 0, load_ready = 1
  - load_valid is ignored until the first rising edge with reset_n = 1.
- States:
  - IDLE: no frame in progress.
  - SHIFT: frame in progress.
  - PARITY: present only with the optional feature.
- Handshake:
  - A transfer occurs on a rising edge where load_valid = 1 and load_ready = 1.
  - data_in is sampled on that edge only.
  - load_ready is combinational: 1 in IDLE; in SHIFT or PARITY, 1 only on the cycle where last_bit = 1; 0 otherwise.
- Latency: first bit (data_in[N-1]) appears on serial_out in the cycle after the accepting edge.
- IDLE -> SHIFT on a transfer:
  - Load shift register with data_in.
  - Counter = 0; frame_active = 1.
- SHIFT:
  - Each edge shifts left by one and fills with 0; counter increments.
  - serial_out = shift_reg[N-1] (combinational from the register).
  - Counter N-1 is the final bit: last_bit = 1.
- Final-bit edge:
  - With a transfer (back-to-back): reload from data_in, counter = 0, stay in SHIFT. No idle cycle between frames.
  - Without a transfer: go to IDLE; serial_out = 0, frame_active = 0.
- Frame length: exactly N cycles with frame_active = 1 per word (N+1 with the optional feature).
- load_valid while load_ready = 0 is ignored. The word is not queued; the source must hold load_valid until accepted.
- data_in changes while busy have no effect on the frame in progress.
- Reset mid-frame aborts immediately; no partial bits follow after reset release.
- Counter width: $clog2(N) bits. Wrap is never used; the counter always reloads to 0.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - After the N data bits, the block enters PARITY for one cycle and drives the even-parity bit (XOR of the accepted word, captured at load) on serial_out.
  - frame_active = 1 during that cycle.
  - last_bit moves from the final data bit to the parity cycle, and load_ready follows it.
  - The back-to-back reload happens from PARITY.
- Undefined:
  - No PARITY state and no parity register.
  - Frame is exactly N bits; behaviour exactly as described above.

Test Plan:
- Reset then N=8, load 0xA5 with load_valid held 1 cycle -> next 8 cycles serial_out = 1,0,1,0,0,1,0,1; frame_active = 1 for those 8; last_bit = 1 on cycle 8 only; then serial_out = 0, load_ready = 1.
- Back-to-back: load 0xFF, hold load_valid with 0x00 presented -> accepted on the last_bit cycle; serial_out = eight 1s immediately followed by eight 0s, frame_active continuously 1 for 16 cycles.
- Busy rejection: load 0x81, assert load_valid with 0x3C on cycles 2-5 of the frame only -> 0x3C never transmitted; output 1,0,0,0,0,0,0,1 then idle.
- Reset mid-frame: load 0xF0, assert reset_n = 0 asynchronously after 3 bits -> serial_out, frame_active, last_bit drop to 0 immediately, load_ready = 1; after release with no load_valid, serial_out stays 0.
- PISO_PARITY_EN defined:
  - load 0xA5 -> 9-bit frame ending with parity bit 0, last_bit on cycle 9.
  - load 0x07 -> 9th bit = 1.
- Handshake timing: load_valid asserted in IDLE with data 0x01 -> load_ready = 1 that cycle; first serial bit 0 one cycle later; serial_out = 1 on cycle 8 together with last_bit.
